apb_master_bridge: RTL

//  APB requester (initiator) that turns a single-outstanding valid/ready command stream into
//  APB SETUP/ACCESS transfers, and returns read data and error status on a valid/ready

---
 rtl/apb_master_bridge.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: turns a single-outstanding valid/ready command into one APB
// SETUP/ACCESS transfer and returns read data / error on a valid/ready response.
module apb_master_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic                  pwrite,
   output logic                  psel,
   output logic                  penable,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [31:0] ABORT_PATTERN = 32'hDEADBEEF;
   localparam logic [DATA_WIDTH-1:0] ABORT_RDATA = DATA_WIDTH'(ABORT_PATTERN);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t state, state_nxt;

   logic [CNT_WIDTH-1:0]  wait_cnt, wait_cnt_nxt;
   logic [ADDR_WIDTH-1:0] paddr_nxt;
   logic [DATA_WIDTH-1:0] pwdata_nxt;
   logic                  pwrite_nxt;
   logic                  psel_nxt;
   logic                  penable_nxt;
   logic                  rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
   logic                  rsp_err_nxt;

   // state resets to IDLE, so cmd_ready must be masked while reset is held
   assign cmd_ready = (state == IDLE) && !preset;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         paddr     <= '0;
         pwdata    <= '0;
         pwrite    <= 1'b0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         paddr     <= paddr_nxt;
         pwdata    <= pwdata_nxt;
         pwrite    <= pwrite_nxt;
         psel      <= psel_nxt;
         penable   <= penable_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      paddr_nxt     = paddr;
      pwdata_nxt    = pwdata;
      pwrite_nxt    = pwrite;
      psel_nxt      = psel;
      penable_nxt   = penable;
      rsp_valid_nxt = rsp_valid;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;

      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               paddr_nxt    = cmd_addr;
               pwdata_nxt   = cmd_wdata;
               pwrite_nxt   = cmd_write;
               psel_nxt     = 1'b1;
               penable_nxt  = 1'b0;
               wait_cnt_nxt = '0;
               state_nxt    = SETUP;
            end
         end
         SETUP: begin
            penable_nxt = 1'b1;
            state_nxt   = ACCESS;
         end
         ACCESS: begin
            // a completion in the last allowed wait cycle beats the watchdog
            if (pready) begin
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = pwrite ? '0 : prdata;
               rsp_err_nxt   = pslverr;
               state_nxt     = RESP;
            end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = ABORT_RDATA;
               rsp_err_nxt   = 1'b1;
               wait_cnt_nxt  = CNT_MAX;
               state_nxt     = RESP;
            end else if (wait_cnt != CNT_MAX) begin
               wait_cnt_nxt = wait_cnt + CNT_WIDTH'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
